// File: rtl/pipe_hazard_ctrl_if.sv
// Hazard-control bundle between the pipeline datapath and the hazard controller.
// The slave modport is the controller side; the master modport is the datapath side.
interface pipe_hazard_ctrl_if;
    logic        mem_wait;
    logic        isLd_ALU;
    logic [4:0]  rd_ALU;
    logic [4:0]  RP1_OF;
    logic [4:0]  RP2_OF;
    logic        useRP1_OF;
    logic        useRP2_OF;
    logic        isBranchTaken;
    logic        isMulti_ALU;
    logic        multi_done;
    logic        stall_PC;
    logic        stall_IFOF;
    logic        stall_OFALU;
    logic        stall_ALUMA;
    logic        stall_MARW;
    logic        flush_IFOF;
    logic        flush_OFALU;
    logic        flush_ALUMA;
    logic        multi_start;
    logic        multi_err;
    logic [15:0] stall_cycles;
    logic [15:0] flush_events;

    modport slave (
        input  mem_wait, isLd_ALU, rd_ALU, RP1_OF, RP2_OF, useRP1_OF, useRP2_OF,
               isBranchTaken, isMulti_ALU, multi_done,
        output stall_PC, stall_IFOF, stall_OFALU, stall_ALUMA, stall_MARW,
               flush_IFOF, flush_OFALU, flush_ALUMA, multi_start, multi_err,
               stall_cycles, flush_events
    );

    modport master (
        output mem_wait, isLd_ALU, rd_ALU, RP1_OF, RP2_OF, useRP1_OF, useRP2_OF,
               isBranchTaken, isMulti_ALU, multi_done,
        input  stall_PC, stall_IFOF, stall_OFALU, stall_ALUMA, stall_MARW,
               flush_IFOF, flush_OFALU, flush_ALUMA, multi_start, multi_err,
               stall_cycles, flush_events
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Five-stage pipeline hazard controller: memory wait, multicycle sequencing with
// watchdog, taken-branch flush and load-use interlock, plus event counters.
module pipe_hazard_ctrl (
    input  logic              clk,
    input  logic              rst_n,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] BUSY = 1'b1;

    logic [0:0]  state, state_nxt;
    logic [7:0]  wdog, wdog_nxt;
    logic        err_set;
    logic        load_use;
    logic        s_pc, s_ifof, s_ofalu, s_aluma, s_marw;
    logic        f_ifof, f_ofalu, f_aluma, m_start;
    logic        multi_err;
    logic [15:0] stall_cycles, flush_events;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v, input logic en);
        if (en && (v != 16'hFFFF))
            return v + 16'd1;
        return v;
    endfunction

    assign load_use = hz.isLd_ALU &&
                      ((hz.useRP1_OF && (hz.RP1_OF == hz.rd_ALU)) ||
                       (hz.useRP2_OF && (hz.RP2_OF == hz.rd_ALU)));

    always_comb begin
        s_pc      = 1'b0;
        s_ifof    = 1'b0;
        s_ofalu   = 1'b0;
        s_aluma   = 1'b0;
        s_marw    = 1'b0;
        f_ifof    = 1'b0;
        f_ofalu   = 1'b0;
        f_aluma   = 1'b0;
        m_start   = 1'b0;
        err_set   = 1'b0;
        state_nxt = state;
        wdog_nxt  = wdog;
        if (hz.mem_wait) begin
            // Whole pipe frozen; FSM and watchdog hold so a completion seen now is retried later.
            s_pc    = 1'b1;
            s_ifof  = 1'b1;
            s_ofalu = 1'b1;
            s_aluma = 1'b1;
            s_marw  = 1'b1;
        end else if (state == BUSY) begin
            if (hz.multi_done) begin
                state_nxt = IDLE;
                wdog_nxt  = 8'd0;
            end else begin
                s_pc    = 1'b1;
                s_ifof  = 1'b1;
                s_ofalu = 1'b1;
                f_aluma = 1'b1;
                if (wdog == 8'hFF) begin
                    err_set   = 1'b1;
                    state_nxt = IDLE;
                    wdog_nxt  = 8'd0;
                end else begin
                    wdog_nxt = wdog + 8'd1;
                end
            end
        end else if (hz.isMulti_ALU) begin
            m_start   = 1'b1;
            s_pc      = 1'b1;
            s_ifof    = 1'b1;
            s_ofalu   = 1'b1;
            f_aluma   = 1'b1;
            state_nxt = BUSY;
            wdog_nxt  = 8'd0;
        end else if (hz.isBranchTaken) begin
            f_ifof  = 1'b1;
            f_ofalu = 1'b1;
        end else if (load_use) begin
            s_pc    = 1'b1;
            s_ifof  = 1'b1;
            f_ofalu = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            wdog         <= 8'd0;
            multi_err    <= 1'b0;
            stall_cycles <= 16'd0;
            flush_events <= 16'd0;
        end else begin
            state        <= state_nxt;
            wdog         <= wdog_nxt;
            multi_err    <= multi_err | err_set;
            stall_cycles <= sat_inc16(stall_cycles, s_pc);
            flush_events <= sat_inc16(flush_events, f_ifof | f_ofalu | f_aluma);
        end
    end

    // Reset gating keeps the controls quiet while rst_n is low, independent of inputs.
    assign hz.stall_PC     = rst_n & s_pc;
    assign hz.stall_IFOF   = rst_n & s_ifof;
    assign hz.stall_OFALU  = rst_n & s_ofalu;
    assign hz.stall_ALUMA  = rst_n & s_aluma;
    assign hz.stall_MARW   = rst_n & s_marw;
    assign hz.flush_IFOF   = rst_n & f_ifof;
    assign hz.flush_OFALU  = rst_n & f_ofalu;
    assign hz.flush_ALUMA  = rst_n & f_aluma;
    assign hz.multi_start  = rst_n & m_start;
    assign hz.multi_err    = multi_err;
    assign hz.stall_cycles = stall_cycles;
    assign hz.flush_events = flush_events;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: expected control vectors are queued as each
// step is driven and popped for comparison at the following falling edge.
module tb_pipe_hazard_ctrl;
    logic clk;
    logic rst_n;

    pipe_hazard_ctrl_if hif ();

    pipe_hazard_ctrl dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Vector order: stall PC,IFOF,OFALU,ALUMA,MARW | flush IFOF,OFALU,ALUMA | multi_start
    localparam logic [8:0] NONE   = 9'b00000_000_0;
    localparam logic [8:0] MEMW   = 9'b11111_000_0;
    localparam logic [8:0] ISSUE  = 9'b11100_001_1;
    localparam logic [8:0] BUSYV  = 9'b11100_001_0;
    localparam logic [8:0] BRANCH = 9'b00000_110_0;
    localparam logic [8:0] LDUSE  = 9'b11000_010_0;

    typedef struct {
        string      tag;
        logic [8:0] vec;
    } exp_t;

    exp_t exp_q[$];
    int   n_assert = 0;
    int   n_fail   = 0;
    int   sc_exp   = 0;
    int   fe_exp   = 0;
    logic err_exp  = 1'b0;

    function automatic logic [8:0] observed();
        return {hif.stall_PC, hif.stall_IFOF, hif.stall_OFALU, hif.stall_ALUMA, hif.stall_MARW,
                hif.flush_IFOF, hif.flush_OFALU, hif.flush_ALUMA, hif.multi_start};
    endfunction

    task automatic pop_cmp();
        exp_t e;
        logic [8:0] obs;
        if (exp_q.size() == 0) begin
            n_assert++;
            n_fail++;
            $error("FAIL scoreboard_empty: got 0 entries expected 1");
            return;
        end
        e   = exp_q.pop_front();
        obs = observed();
        n_assert++;
        assert (obs === e.vec) else begin
            n_fail++;
            $error("FAIL %s: got %b expected %b", e.tag, obs, e.vec);
        end
        if (rst_n) begin
            if (e.vec[8]) sc_exp++;
            if (|e.vec[3:1]) fe_exp++;
        end
    endtask

    task automatic set_in(input logic mw, input logic ld, input logic [4:0] rd,
                          input logic [4:0] rp1, input logic [4:0] rp2,
                          input logic u1, input logic u2, input logic br,
                          input logic mu, input logic md);
        hif.mem_wait      = mw;
        hif.isLd_ALU      = ld;
        hif.rd_ALU        = rd;
        hif.RP1_OF        = rp1;
        hif.RP2_OF        = rp2;
        hif.useRP1_OF     = u1;
        hif.useRP2_OF     = u2;
        hif.isBranchTaken = br;
        hif.isMulti_ALU   = mu;
        hif.multi_done    = md;
    endtask

    task automatic step(input string tag, input logic mw, input logic ld, input logic [4:0] rd,
                        input logic [4:0] rp1, input logic [4:0] rp2,
                        input logic u1, input logic u2, input logic br,
                        input logic mu, input logic md, input logic [8:0] vec);
        exp_t e;
        set_in(mw, ld, rd, rp1, rp2, u1, u2, br, mu, md);
        e.tag = tag;
        e.vec = vec;
        exp_q.push_back(e);
        @(negedge clk);
        pop_cmp();
        @(posedge clk);
        #1;
    endtask

    task automatic check_cnt(input string tag);
        n_assert++;
        assert (hif.stall_cycles === 16'(sc_exp)) else begin
            n_fail++;
            $error("FAIL %s_stall_cycles: got %0d expected %0d", tag, hif.stall_cycles, sc_exp);
        end
        n_assert++;
        assert (hif.flush_events === 16'(fe_exp)) else begin
            n_fail++;
            $error("FAIL %s_flush_events: got %0d expected %0d", tag, hif.flush_events, fe_exp);
        end
        n_assert++;
        assert (hif.multi_err === err_exp) else begin
            n_fail++;
            $error("FAIL %s_multi_err: got %b expected %b", tag, hif.multi_err, err_exp);
        end
    endtask

    initial begin
        exp_t e;
        // Reset with hostile inputs: everything must be quiet.
        rst_n = 1'b0;
        step("reset_outputs", 1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 1, NONE);
        check_cnt("reset");
        @(negedge clk);
        rst_n = 1'b1;
        set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        @(posedge clk);
        #1;

        step("idle", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NONE);
        step("ldu_rp2", 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 0, 0, 0, LDUSE);
        step("ldu_done", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NONE);
        check_cnt("ldu");
        step("ldu_rp1", 0, 1, 5'd7, 5'd7, 5'd3, 1, 0, 0, 0, 0, LDUSE);
        step("ldu_r0", 0, 1, 5'd0, 5'd0, 5'd9, 1, 0, 0, 0, 0, LDUSE);
        step("no_use_flag", 0, 1, 5'd5, 5'd5, 5'd5, 0, 0, 0, 0, 0, NONE);
        step("no_load", 0, 0, 5'd5, 5'd5, 5'd5, 1, 1, 0, 0, 0, NONE);
        step("msb_diff", 0, 1, 5'd21, 5'd5, 5'd5, 1, 1, 0, 0, 0, NONE);
        step("branch_over_ldu", 0, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 0, 0, BRANCH);
        step("memw_over_branch", 1, 1, 5'd5, 5'd0, 5'd5, 0, 1, 1, 0, 0, MEMW);
        check_cnt("mixed");

        // Multicycle op issued at cycle 0, completes at cycle 4.
        step("mc_c0", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, ISSUE);
        step("mc_c1", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, BUSYV);
        step("mc_c2_branch", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, BUSYV);
        step("mc_c3", 0, 1, 5'd5, 5'd5, 5'd0, 1, 0, 0, 0, 0, BUSYV);
        step("mc_c4_done", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, NONE);
        step("mc_c5_idle", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, BRANCH);
        check_cnt("multi");

        // Completion pulse that collides with mem_wait must not be consumed.
        step("mw_issue", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, ISSUE);
        step("mw_busy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, BUSYV);
        step("mw_1", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, MEMW);
        step("mw_2_done", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, MEMW);
        step("mw_3", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, MEMW);
        step("mw_still_busy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, BUSYV);
        step("mw_late_done", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 1, NONE);
        step("mw_after_idle", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NONE);
        check_cnt("memwait");

        // Watchdog: 256 non-waiting BUSY cycles, with a mem_wait pause that must not count.
        step("wd_issue", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, ISSUE);
        for (int i = 0; i < 255; i++) begin
            if (i == 100) begin
                step("wd_pause_a", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, MEMW);
                step("wd_pause_b", 1, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, MEMW);
            end
            step("wd_busy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, BUSYV);
        end
        check_cnt("wd_before");
        step("wd_last", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, BUSYV);
        err_exp = 1'b1;
        check_cnt("wd_timeout");
        step("wd_released", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NONE);
        step("wd_branch", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, 0, BRANCH);
        check_cnt("wd_sticky");

        // Asynchronous reset in the middle of a multicycle op.
        step("ar_issue", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, ISSUE);
        step("ar_busy", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, BUSYV);
        set_in(1, 1, 5'd5, 5'd5, 5'd5, 1, 1, 1, 1, 0);
        #2;
        rst_n = 1'b0;
        #1;
        e.tag = "ar_outputs";
        e.vec = NONE;
        exp_q.push_back(e);
        pop_cmp();
        sc_exp  = 0;
        fe_exp  = 0;
        err_exp = 1'b0;
        check_cnt("ar");
        @(negedge clk);
        set_in(0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        step("ar_no_start", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, 0, NONE);
        step("ar_idle_issue", 0, 0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 1, 0, ISSUE);
        check_cnt("ar_after");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule

// File: doc/pipe_hazard_ctrl.md
PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 SHALL have port: clk  in  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  in  1  asynchronous, active-low reset.
REQ-003 SHALL have port: mem_wait  in  1  data memory not ready in MA stage.
REQ-004 SHALL have ports: isLd_ALU  in  1, rd_ALU  in  5  load present in ALU stage and its destination.
REQ-005 SHALL have ports: RP1_OF  in  5, RP2_OF  in  5, useRP1_OF  in  1, useRP2_OF  in  1  OF-stage source registers and their valid flags.
REQ-006 SHALL have port: isBranchTaken  in  1  taken branch resolved in ALU stage.
REQ-007 SHALL have ports: isMulti_ALU  in  1, multi_done  in  1  multicycle operation in ALU stage; completion pulse from the multicycle unit.
REQ-008 SHALL have outputs: stall_PC, stall_IFOF, stall_OFALU, stall_ALUMA, stall_MARW  each 1  hold the PC or pipe register.
REQ-009 SHALL have outputs: flush_IFOF, flush_OFALU, flush_ALUMA  each 1  load a bubble (all zeros) into the pipe register; effective only while the matching stall is 0.
REQ-010 SHALL have outputs: multi_start  1, multi_err  1 (sticky), stall_cycles  16, flush_events  16.

Function
REQ-011 SHALL keep a 2-state FSM: IDLE, BUSY; multi_start, stall and flush outputs SHALL be combinational from state and inputs.
REQ-012 SHALL apply priority, highest first: mem_wait > BUSY/multi issue > isBranchTaken > load-use.
REQ-013 SHALL, on mem_wait=1: all five stalls =1, all flushes =0, multi_start =0, FSM state and watchdog held.
REQ-014 SHALL, in IDLE with isMulti_ALU=1 and mem_wait=0: multi_start=1 for that cycle; stall_PC, stall_IFOF, stall_OFALU =1; flush_ALUMA =1; next state BUSY.
REQ-015 SHALL, in BUSY with multi_done=0: same stalls and flush_ALUMA as REQ-014; multi_start=0; watchdog increments.
REQ-016 SHALL, in BUSY with multi_done=1: no stalls, no flushes for that cycle (result advances to MA); next state IDLE; watchdog cleared.
REQ-017 SHALL keep an 8-bit watchdog; on BUSY with watchdog=255 and multi_done=0: set multi_err=1, go to IDLE, release stalls next cycle.
REQ-018 SHALL, on isBranchTaken=1 (no higher priority active): flush_IFOF=1, flush_OFALU=1, no stalls.
REQ-019 SHALL detect load-use when isLd_ALU=1 and ((useRP1_OF and RP1_OF==rd_ALU) or (useRP2_OF and RP2_OF==rd_ALU)); all 5 bits compared, no register excluded.
REQ-020 SHALL, on load-use (no higher priority): stall_PC=1, stall_IFOF=1, flush_OFALU=1 for exactly that cycle.
REQ-021 SHALL, when no condition is active: all stalls and flushes =0.
REQ-022 SHALL increment stall_cycles on every cycle with stall_PC=1, saturating at 16'hFFFF.
REQ-023 SHALL increment flush_events by 1 per cycle in which any flush is 1, saturating at 16'hFFFF.
REQ-024 SHALL, on simultaneous multi_done=1 and mem_wait=1: hold BUSY (mem_wait wins); completion is consumed on a later cycle with mem_wait=0 and multi_done=1.

Reset
REQ-025 SHALL, while rst_n=0: state=IDLE, watchdog=0, multi_err=0, stall_cycles=0, flush_events=0, and all stall, flush and multi_start outputs forced to 0 regardless of inputs.
REQ-026 SHALL, on rst_n assertion mid-BUSY: return to IDLE immediately without waiting for a clock edge; no multi_start is issued in the first cycle after deassertion unless isMulti_ALU=1.

Verification
REQ-027 SHALL cover load-use: isLd_ALU=1, rd_ALU=5, RP2_OF=5, useRP2_OF=1 for 1 cycle -> stall_PC=stall_IFOF=flush_OFALU=1 for 1 cycle, stall_cycles=1, flush_events=1.
REQ-028 SHALL cover branch over load-use: isBranchTaken=1 together with a REQ-027 hazard -> flush_IFOF=flush_OFALU=1, stall_PC=0.
REQ-029 SHALL cover multicycle: isMulti_ALU=1 at cycle 0, multi_done at cycle 4 -> multi_start at cycle 0 only; stalls and flush_ALUMA on cycles 0-3; all 0 at cycle 4; state IDLE at cycle 5.
REQ-030 SHALL cover mem_wait during BUSY: mem_wait=1 for 3 cycles with multi_done=1 on the 2nd -> all five stalls 1 for 3 cycles; still BUSY afterwards; watchdog unchanged.
REQ-031 SHALL cover watchdog: isMulti_ALU=1, multi_done never asserted -> multi_err=1 after 256 BUSY cycles, stalls released the next cycle, multi_err stays 1 until reset.
REQ-032 SHALL cover async reset mid-BUSY: rst_n=0 between clock edges -> outputs 0 immediately, counters 0.
